// File: rtl/vga_timing_pkg.sv
// Shared timing constants, colour defaults and pipeline helpers for the
// framebuffer scanout block.
package vga_timing_pkg;

  // Standard 640x480@60 timing, in pixel clocks and lines
  localparam int SCREEN_WIDTH_DEF  = 640;
  localparam int SCREEN_HEIGHT_DEF = 480;
  localparam int H_FRONT_DEF       = 16;
  localparam int H_SYNC_DEF        = 96;
  localparam int H_BACK_DEF        = 48;
  localparam int V_FRONT_DEF       = 10;
  localparam int V_SYNC_DEF        = 2;
  localparam int V_BACK_DEF        = 33;

  localparam int H_TOTAL_DEF       = SCREEN_WIDTH_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF       = SCREEN_HEIGHT_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START_DEF  = SCREEN_WIDTH_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF    = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF  = SCREEN_HEIGHT_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF    = V_SYNC_START_DEF + V_SYNC_DEF;

  // Default 4:4:4 colours: green trace on black
  localparam int              COLOR_WIDTH_DEF = 12;
  localparam logic [11:0]     FG_COLOR_DEF    = 12'h0F0;
  localparam logic [11:0]     BG_COLOR_DEF    = 12'h000;

  // Control bits that travel alongside the framebuffer read.
  // Sync flags are stored active-high so a cleared stage means "not in sync".
  typedef struct packed {
    logic active;
    logic hs_on;
    logic vs_on;
  } vga_ctl_t;

  // Counter-to-output latency: the memory read plus one output register.
  function automatic int pipe_latency(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical position counters, active-area and raw sync decode,
// and the start-of-vertical-blanking pulse.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int H_FRONT       = H_FRONT_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BACK        = H_BACK_DEF,
  parameter int V_FRONT       = V_FRONT_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BACK        = V_BACK_DEF
) (
  input  logic clk,
  input  logic resetn,
  output logic active,
  output logic hs_raw,
  output logic vs_raw,
  output logic frame_end,
  output logic vblank_start
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(SCREEN_WIDTH);
  localparam logic [H_W-1:0] HS_START = H_W'(SCREEN_WIDTH + H_FRONT);
  localparam logic [H_W-1:0] HS_END   = H_W'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(SCREEN_HEIGHT);
  localparam logic [V_W-1:0] VS_START = V_W'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [V_W-1:0] VS_END   = V_W'(SCREEN_HEIGHT + V_FRONT + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           line_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // Raster position: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw = ~((v_cnt >= VS_START) && (v_cnt < VS_END));

  // One-clock pulse right after the raster enters the first blank line;
  // taken straight from the counters so the writer is told as early as possible
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vblank_start <= 1'b0;
    end else begin
      vblank_start <= (h_cnt == '0) && (v_cnt == V_ACT);
    end
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer reader: walks the 1-bit buffer in raster order, aligns sync
// with the returning read data, colours each pixel and optionally zeroes it
// behind the beam so every frame starts blank.
module vga_fb_scanout
  import vga_timing_pkg::*;
#(
  parameter int                     SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int                     SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int                     H_FRONT       = H_FRONT_DEF,
  parameter int                     H_SYNC        = H_SYNC_DEF,
  parameter int                     H_BACK        = H_BACK_DEF,
  parameter int                     V_FRONT       = V_FRONT_DEF,
  parameter int                     V_SYNC        = V_SYNC_DEF,
  parameter int                     V_BACK        = V_BACK_DEF,
  parameter int                     ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter int                     RD_LATENCY    = 2,   // 1..4
  parameter int                     COLOR_WIDTH   = COLOR_WIDTH_DEF,
  parameter logic [COLOR_WIDTH-1:0] FG_COLOR      = COLOR_WIDTH'(FG_COLOR_DEF),
  parameter logic [COLOR_WIDTH-1:0] BG_COLOR      = COLOR_WIDTH'(BG_COLOR_DEF)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear_en,
  output logic [ADDR_WIDTH-1:0]  fb_rd_addr,
  output logic                   fb_rd_en,
  input  logic                   fb_rd_data,
  output logic [ADDR_WIDTH-1:0]  fb_clr_addr,
  output logic                   fb_clr_wr_en,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_WIDTH-1:0] vga_rgb,
  output logic                   vblank_start
);

  // Everything except the final output register lines up with the read data
  localparam int ALIGN_DEPTH = pipe_latency(RD_LATENCY) - 1;

  logic                  active;
  logic                  hs_raw;
  logic                  vs_raw;
  logic                  frame_end;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  clr_mode;
  vga_ctl_t              ctl_now;
  vga_ctl_t              ctl_pipe  [ALIGN_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_pipe [ALIGN_DEPTH];
  vga_ctl_t              data_ctl;
  logic [ADDR_WIDTH-1:0] data_addr;

  vga_timing_gen #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .H_FRONT       (H_FRONT),
    .H_SYNC        (H_SYNC),
    .H_BACK        (H_BACK),
    .V_FRONT       (V_FRONT),
    .V_SYNC        (V_SYNC),
    .V_BACK        (V_BACK)
  ) u_timing (
    .clk          (clk),
    .resetn       (resetn),
    .active       (active),
    .hs_raw       (hs_raw),
    .vs_raw       (vs_raw),
    .frame_end    (frame_end),
    .vblank_start (vblank_start)
  );

  // Raster-order read address, stepped only on visible pixels so no multiply is needed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_cnt <= '0;
    end else if (frame_end) begin
      addr_cnt <= '0;
    end else if (active) begin
      addr_cnt <= addr_cnt + 1'b1;
    end
  end

  // The counters sit at (0,0) during reset, so the strobe is gated by resetn
  // to keep the memory idle until the raster actually starts.
  assign fb_rd_addr = addr_cnt;
  assign fb_rd_en   = active & resetn;

  assign ctl_now = '{active: active, hs_on: ~hs_raw, vs_on: ~vs_raw};

  // Delay control bits and address by the memory read latency; clearing the
  // stages on reset guarantees no stale pixel is ever displayed or cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ALIGN_DEPTH; i++) begin
        ctl_pipe[i]  <= '0;
        addr_pipe[i] <= '0;
      end
    end else begin
      ctl_pipe[0]  <= ctl_now;
      addr_pipe[0] <= addr_cnt;
      for (int i = 1; i < ALIGN_DEPTH; i++) begin
        ctl_pipe[i]  <= ctl_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign data_ctl  = ctl_pipe[ALIGN_DEPTH-1];
  assign data_addr = addr_pipe[ALIGN_DEPTH-1];

  // Output register: sync and colour leave together; blanking is forced to black
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_rgb   <= '0;
    end else begin
      vga_hsync <= ~data_ctl.hs_on;
      vga_vsync <= ~data_ctl.vs_on;
      vga_rgb   <= data_ctl.active ? (fb_rd_data ? FG_COLOR : BG_COLOR) : '0;
    end
  end

  // Read-and-clear request is only sampled at the vblank pulse, so a frame
  // is either cleared completely or not at all
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_mode <= 1'b0;
    end else if (vblank_start) begin
      clr_mode <= clear_en;
    end
  end

  // Zero each pixel in the same cycle its data comes back from the buffer
  assign fb_clr_wr_en = clr_mode & data_ctl.active;
  assign fb_clr_addr  = data_addr;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a shrunken raster (16x8 visible,
// 25x13 total) so several whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_fb_scanout;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = W + HF + HS + HB;   // 25
  localparam int VT = H + VF + VS + VB;   // 13
  localparam int FRAME = HT * VT;         // 325
  localparam int AW = 7;
  localparam int NPIX = W * H;            // 128
  localparam logic [11:0] FG = 12'h0F0;
  localparam logic [11:0] BG = 12'h000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clear_en = 1'b0;
  logic [AW-1:0] fb_rd_addr;
  logic          fb_rd_en;
  logic          fb_rd_data;
  logic [AW-1:0] fb_clr_addr;
  logic          fb_clr_wr_en;
  logic          vga_hsync;
  logic          vga_vsync;
  logic [11:0]   vga_rgb;
  logic          vblank_start;

  always #5 clk = ~clk;

  vga_fb_scanout #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .H_FRONT       (HF),
    .H_SYNC        (HS),
    .H_BACK        (HB),
    .V_FRONT       (VF),
    .V_SYNC        (VS),
    .V_BACK        (VB),
    .ADDR_WIDTH    (AW),
    .RD_LATENCY    (2),
    .COLOR_WIDTH   (12),
    .FG_COLOR      (FG),
    .BG_COLOR      (BG)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clear_en     (clear_en),
    .fb_rd_addr   (fb_rd_addr),
    .fb_rd_en     (fb_rd_en),
    .fb_rd_data   (fb_rd_data),
    .fb_clr_addr  (fb_clr_addr),
    .fb_clr_wr_en (fb_clr_wr_en),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .vga_rgb      (vga_rgb),
    .vblank_start (vblank_start)
  );

  // Framebuffer model: 2-clock read, clear port writes 0; fill_mode loads images
  logic mem [NPIX];
  logic rd_s1;
  int   fill_mode = 0;   // 0 none, 1 all ones, 2 only address 21 set

  always @(posedge clk) begin
    rd_s1      <= mem[fb_rd_addr];
    fb_rd_data <= rd_s1;
    if (fill_mode == 1) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= 1'b1;
    end else if (fill_mode == 2) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= (i == 21);
    end else if (fb_clr_wr_en) begin
      mem[fb_clr_addr] <= 1'b0;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;
  int fr_base = 0;
  int hs_run = 0;
  int vb_cnt = 0;
  int fg_cnt [6];
  int clr_cnt [6];
  int hs_low [6];
  int vs_low [6];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Image the model memory holds while frame fr is scanned
  function automatic bit exp_pix(input int fr, input int addr);
    case (fr)
      0:       return (addr == 21);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Compare every DUT output for interval k (k clock edges after reset release)
  task automatic check_interval(input int k);
    int  p, h, v, fr;
    bit  act, exp_clr, exp_hs, exp_vs, exp_vb;
    logic [11:0] exp_rgb;
    // counter stage: position k
    p = k % FRAME; h = p % HT; v = p / HT;
    act = (h < W) && (v < H);
    check_val($sformatf("rd_en k=%0d", k), {31'd0, fb_rd_en}, {31'd0, act});
    if (act) check_val($sformatf("rd_addr k=%0d", k), {25'd0, fb_rd_addr}, v * W + h);
    // clear port: position k-2 (data return)
    exp_clr = 1'b0;
    if (k >= 2) begin
      p = (k - 2) % FRAME; h = p % HT; v = p / HT; fr = fr_base + (k - 2) / FRAME;
      exp_clr = (h < W) && (v < H) && (fr == 1);
      if (fb_clr_wr_en) clr_cnt[fr]++;
      if (exp_clr) check_val($sformatf("clr_addr k=%0d", k), {25'd0, fb_clr_addr}, v * W + h);
    end
    check_val($sformatf("clr_wr_en k=%0d", k), {31'd0, fb_clr_wr_en}, {31'd0, exp_clr});
    // outputs: position k-3
    exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
    if (k >= 3) begin
      p = (k - 3) % FRAME; h = p % HT; v = p / HT; fr = fr_base + (k - 3) / FRAME;
      exp_hs = !((h >= W + HF) && (h < W + HF + HS));
      exp_vs = !((v >= H + VF) && (v < H + VF + VS));
      if ((h < W) && (v < H)) exp_rgb = exp_pix(fr, v * W + h) ? FG : BG;
      if (vga_rgb == FG) fg_cnt[fr]++;
      if (!vga_hsync) hs_low[fr]++;
      if (!vga_vsync) vs_low[fr]++;
      if (!vga_hsync) begin
        hs_run++;
      end else if (hs_run > 0) begin
        check_val($sformatf("hs_pulse_len k=%0d", k), hs_run, HS);
        hs_run = 0;
      end
    end
    check_val($sformatf("hsync k=%0d", k), {31'd0, vga_hsync}, {31'd0, exp_hs});
    check_val($sformatf("vsync k=%0d", k), {31'd0, vga_vsync}, {31'd0, exp_vs});
    check_val($sformatf("rgb k=%0d", k), {20'd0, vga_rgb}, {20'd0, exp_rgb});
    exp_vb = (k >= 1) && (((k - 1) % FRAME) == H * HT);
    if (vblank_start) vb_cnt++;
    check_val($sformatf("vblank k=%0d", k), {31'd0, vblank_start}, {31'd0, exp_vb});
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_hsync"}, {31'd0, vga_hsync}, 32'd1);
    check_val({pfx, "_vsync"}, {31'd0, vga_vsync}, 32'd1);
    check_val({pfx, "_rgb"}, {20'd0, vga_rgb}, 32'd0);
    check_val({pfx, "_rd_en"}, {31'd0, fb_rd_en}, 32'd0);
    check_val({pfx, "_clr_wr_en"}, {31'd0, fb_clr_wr_en}, 32'd0);
    check_val({pfx, "_vblank"}, {31'd0, vblank_start}, 32'd0);
  endtask

  initial begin
    int ones;
    for (int i = 0; i < 6; i++) begin
      fg_cnt[i] = 0; clr_cnt[i] = 0; hs_low[i] = 0; vs_low[i] = 0;
    end
    // Reset with the single-pixel image loaded
    fill_mode = 2;
    repeat (4) @(posedge clk);
    @(negedge clk);
    fill_mode = 0;
    check_reset_outputs("reset");
    $display("[TB] reset values checked");

    // Release and scan frames 0..3; frame 1 is read-and-clear
    resetn = 1'b1;
    #1;
    check_val("first_rd_addr", {25'd0, fb_rd_addr}, 32'd0);
    check_interval(0);
    for (int k = 1; k <= 3 * FRAME + 4 * HT + 12; k++) begin
      @(negedge clk);
      check_interval(k);
      fill_mode = 0;
      case (k)
        150: clear_en = 1'b1;
        250: fill_mode = 1;
        500: clear_en = 1'b0;
        640: begin
          ones = 0;
          for (int i = 0; i < NPIX; i++) if (mem[i]) ones++;
          check_val("mem_cleared_after_frame1", ones, 0);
        end
        700: clear_en = 1'b1;   // mid-frame request, gone again before vblank
        800: clear_en = 1'b0;
        900: fill_mode = 1;
        default: ;
      endcase
      if ((k % FRAME) == FRAME - 1) $display("[TB] frame %0d scanned", k / FRAME);
    end

    // Mid-frame reset at (h=12, v=4) of frame 3, while FG pixels are on screen
    check_val("pre_reset_rgb", {20'd0, vga_rgb}, {20'd0, FG});
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    $display("[TB] mid-frame reset applied");
    check_val("vblank_total_run1", vb_cnt, 3);
    check_val("fg_frame0", fg_cnt[0], 1);
    check_val("fg_frame1", fg_cnt[1], NPIX);
    check_val("fg_frame2", fg_cnt[2], 0);
    check_val("clr_frame0", clr_cnt[0], 0);
    check_val("clr_frame1", clr_cnt[1], NPIX);
    check_val("clr_frame2", clr_cnt[2], 0);
    check_val("hs_low_frame0", hs_low[0], VT * HS);
    check_val("vs_low_frame0", vs_low[0], VS * HT);

    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    fr_base = 4;
    hs_run = 0;
    vb_cnt = 0;
    check_val("restart_rd_addr", {25'd0, fb_rd_addr}, 32'd0);
    check_interval(0);
    for (int k = 1; k <= FRAME + 10; k++) begin
      @(negedge clk);
      check_interval(k);
    end
    $display("[TB] frame after restart scanned");
    check_val("fg_frame_restart", fg_cnt[4], NPIX);
    check_val("vblank_total_run2", vb_cnt, 1);
    check_val("clr_after_restart", clr_cnt[4], 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
